// File: rtl/alu_sequencer.sv
// Sequences the shared 6502 ALU for one operation per command; valid/ready on both sides.
// Optional BCD correction pass for ADC when ALU_SEQ_DECIMAL_EN is defined (adds cmd_d).
module alu_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_c,
`ifdef ALU_SEQ_DECIMAL_EN
    input  logic              cmd_d,
`endif
    output logic [2:0]        alu_control,
    output logic [DATA_W-1:0] alu_AI,
    output logic [DATA_W-1:0] alu_BI,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_Y,
    input  logic              alu_carry_out,
    input  logic              alu_overflow,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [3:0]        res_flags,
    output logic [3:0]        res_flag_we,
    output logic              res_wb,
    output logic              res_err
);

    // ALU control encoding shared with the 6502 ALU
    localparam logic [2:0] OR  = 3'd0;
    localparam logic [2:0] AND = 3'd1;
    localparam logic [2:0] XOR = 3'd2;
    localparam logic [2:0] ADD = 3'd3;
    localparam logic [2:0] SR  = 3'd4;

    localparam logic [3:0] OP_ADC = 4'h0;
    localparam logic [3:0] OP_SBC = 4'h1;
    localparam logic [3:0] OP_CMP = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_ORA = 4'h4;
    localparam logic [3:0] OP_EOR = 4'h5;
    localparam logic [3:0] OP_ASL = 4'h6;
    localparam logic [3:0] OP_LSR = 4'h7;
    localparam logic [3:0] OP_ROL = 4'h8;
    localparam logic [3:0] OP_ROR = 4'h9;
    localparam logic [3:0] OP_INC = 4'hA;
    localparam logic [3:0] OP_DEC = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
`ifdef ALU_SEQ_DECIMAL_EN
        ,S_FIX = 2'd3
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              w_accept;
    logic [2:0]        w_ctl;
    logic [DATA_W-1:0] w_ai;
    logic [DATA_W-1:0] w_bi;
    logic              w_ci;
    logic [3:0]        w_we;
    logic              w_wb;
    logic              w_illegal;
    logic [3:0]        w_flags;

    logic [3:0]        r_we;
    logic              r_wb;
    logic              r_err;

`ifdef ALU_SEQ_DECIMAL_EN
    logic              r_dec;
    logic              r_bin_c;
    logic              r_bin_v;
    logic              r_corr_hi;
    logic              w_dec;
    logic              w_half;
    logic              w_corr_lo;
    logic              w_corr_hi;
    logic [DATA_W-1:0] w_corr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_EXEC;
            S_EXEC: begin
`ifdef ALU_SEQ_DECIMAL_EN
                if (r_dec && !r_err) w_next = S_FIX;
                else                 w_next = S_DONE;
`else
                w_next = S_DONE;
`endif
            end
`ifdef ALU_SEQ_DECIMAL_EN
            S_FIX:  w_next = S_DONE;
`endif
            S_DONE: if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE) && !reset;
        w_accept  = cmd_valid && cmd_ready;
        w_ctl     = ADD;
        w_ai      = cmd_a;
        w_bi      = cmd_b;
        w_ci      = 1'b0;
        w_we      = 4'b0000;
        w_wb      = 1'b1;
        w_illegal = 1'b0;
        case (cmd_op)
            OP_ADC: begin w_ci = cmd_c; w_we = 4'b1111; end
            OP_SBC: begin w_bi = ~cmd_b; w_ci = cmd_c; w_we = 4'b1111; end
            OP_CMP: begin w_bi = ~cmd_b; w_ci = 1'b1; w_we = 4'b1110; w_wb = 1'b0; end
            OP_AND: begin w_ctl = AND; w_we = 4'b1100; end
            OP_ORA: begin w_ctl = OR;  w_we = 4'b1100; end
            OP_EOR: begin w_ctl = XOR; w_we = 4'b1100; end
            OP_ASL: begin w_bi = cmd_a; w_we = 4'b1110; end
            OP_LSR: begin w_ctl = SR; w_bi = '0; w_we = 4'b1110; end
            OP_ROL: begin w_bi = cmd_a; w_ci = cmd_c; w_we = 4'b1110; end
            OP_ROR: begin w_ctl = SR; w_bi = '0; w_ci = cmd_c; w_we = 4'b1110; end
            OP_INC: begin w_bi = '0; w_ci = 1'b1; w_we = 4'b1100; end
            OP_DEC: begin w_bi = '1; w_we = 4'b1100; end
            default: begin w_illegal = 1'b1; w_wb = 1'b0; end
        endcase
        w_flags = {alu_Y[DATA_W-1], (alu_Y == '0), alu_carry_out, alu_overflow};
`ifdef ALU_SEQ_DECIMAL_EN
        w_dec     = (cmd_op == OP_ADC) && cmd_d;
        w_half    = alu_AI[4] ^ alu_BI[4] ^ alu_Y[4];
        w_corr_lo = w_half || (alu_Y[3:0] > 4'd9);
        w_corr_hi = alu_carry_out || (alu_Y > 8'h99);
        w_corr    = (w_corr_lo ? 8'h06 : 8'h00) + (w_corr_hi ? 8'h60 : 8'h00);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_control  <= ADD;
            alu_AI       <= '0;
            alu_BI       <= '0;
            alu_carry_in <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_flags    <= 4'b0000;
            res_flag_we  <= 4'b0000;
            res_wb       <= 1'b0;
            res_err      <= 1'b0;
            r_we         <= 4'b0000;
            r_wb         <= 1'b0;
            r_err        <= 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
            r_dec        <= 1'b0;
            r_bin_c      <= 1'b0;
            r_bin_v      <= 1'b0;
            r_corr_hi    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we  <= w_we;
                        r_wb  <= w_wb;
                        r_err <= w_illegal;
`ifdef ALU_SEQ_DECIMAL_EN
                        r_dec <= w_dec;
`endif
                        // Illegal ops never touch the ALU registers
                        if (!w_illegal) begin
                            alu_control  <= w_ctl;
                            alu_AI       <= w_ai;
                            alu_BI       <= w_bi;
                            alu_carry_in <= w_ci;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_err) begin
                        res_data    <= '0;
                        res_flags   <= 4'b0000;
                        res_flag_we <= 4'b0000;
                        res_wb      <= 1'b0;
                        res_err     <= 1'b1;
                        res_valid   <= 1'b1;
`ifdef ALU_SEQ_DECIMAL_EN
                    end else if (r_dec) begin
                        r_bin_c      <= alu_carry_out;
                        r_bin_v      <= alu_overflow;
                        r_corr_hi    <= w_corr_hi;
                        alu_control  <= ADD;
                        alu_AI       <= alu_Y;
                        alu_BI       <= w_corr;
                        alu_carry_in <= 1'b0;
`endif
                    end else begin
                        res_data    <= alu_Y;
                        res_flags   <= w_flags & r_we;
                        res_flag_we <= r_we;
                        res_wb      <= r_wb;
                        res_err     <= 1'b0;
                        res_valid   <= 1'b1;
                    end
                end
`ifdef ALU_SEQ_DECIMAL_EN
                S_FIX: begin
                    // Carry is the binary carry or the high-digit correction; V stays binary
                    res_data    <= alu_Y;
                    res_flags   <= {alu_Y[DATA_W-1], (alu_Y == '0),
                                    r_bin_c | r_corr_hi, r_bin_v} & r_we;
                    res_flag_we <= r_we;
                    res_wb      <= r_wb;
                    res_err     <= 1'b0;
                    res_valid   <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed test of alu_sequencer against a behavioural 6502 ALU model.
module tb_alu_sequencer;

    localparam logic [2:0] OR  = 3'd0;
    localparam logic [2:0] AND = 3'd1;
    localparam logic [2:0] XOR = 3'd2;
    localparam logic [2:0] ADD = 3'd3;
    localparam logic [2:0] SR  = 3'd4;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_c;
`ifdef ALU_SEQ_DECIMAL_EN
    logic       cmd_d;
`endif
    logic [2:0] alu_control;
    logic [7:0] alu_AI;
    logic [7:0] alu_BI;
    logic       alu_carry_in;
    logic [7:0] alu_Y;
    logic       alu_carry_out;
    logic       alu_overflow;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_flags;
    logic [3:0] res_flag_we;
    logic       res_wb;
    logic       res_err;

    int n_tests;
    int n_fail;

    alu_sequencer #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
`ifdef ALU_SEQ_DECIMAL_EN
        .cmd_d(cmd_d),
`endif
        .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI),
        .alu_carry_in(alu_carry_in), .alu_Y(alu_Y),
        .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .res_flag_we(res_flag_we),
        .res_wb(res_wb), .res_err(res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    logic [8:0] sum;
    always_comb begin
        sum           = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'd0, alu_carry_in};
        alu_Y         = 8'h00;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        case (alu_control)
            OR:  alu_Y = alu_AI | alu_BI;
            AND: alu_Y = alu_AI & alu_BI;
            XOR: alu_Y = alu_AI ^ alu_BI;
            ADD: begin
                alu_Y         = sum[7:0];
                alu_carry_out = sum[8];
                alu_overflow  = (alu_AI[7] == alu_BI[7]) && (sum[7] != alu_AI[7]);
            end
            SR: begin
                alu_Y         = {alu_carry_in, alu_AI[7:1]};
                alu_carry_out = alu_AI[0];
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a command; returns #1 after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_c     = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int exp_lat, input logic [7:0] exp_data,
                             input logic [3:0] exp_flags, input logic [3:0] exp_we,
                             input logic exp_wb, input logic exp_err);
        int lat;
        lat = 0;
        while (!res_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"},   lat,         exp_lat);
        check({tag, "_data"},  res_data,    exp_data);
        check({tag, "_flags"}, res_flags,   exp_flags);
        check({tag, "_we"},    res_flag_we, exp_we);
        check({tag, "_wb"},    res_wb,      exp_wb);
        check({tag, "_err"},   res_err,     exp_err);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, "_ready_after"}, cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_c     = 1'b0;
        res_ready = 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
        cmd_d     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_alu_ctl",   alu_control, ADD);
        check("rst_res_data",  res_data, 8'h00);
        reset = 1'b0;
        #1;
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // ADC 0x50+0x50
        issue(4'h0, 8'h50, 8'h50, 1'b0);
        check("adc_res_valid_t0", res_valid, 1'b0);
        finish_op("adc", 1, 8'hA0, 4'b1001, 4'b1111, 1'b1, 1'b0);

        // SBC 0x50-0xF0 with C=1
        issue(4'h1, 8'h50, 8'hF0, 1'b1);
        check("sbc_bi", alu_BI, 8'h0F);
        check("sbc_ci", alu_carry_in, 1'b1);
        finish_op("sbc", 1, 8'h60, 4'b0000, 4'b1111, 1'b1, 1'b0);

        issue(4'h2, 8'h40, 8'h40, 1'b0);
        finish_op("cmp", 1, 8'h00, 4'b0110, 4'b1110, 1'b0, 1'b0);

        issue(4'h9, 8'h01, 8'h00, 1'b1);
        check("ror_ctl", alu_control, SR);
        finish_op("ror", 1, 8'h80, 4'b1010, 4'b1110, 1'b1, 1'b0);

        issue(4'h7, 8'h01, 8'h00, 1'b0);
        finish_op("lsr", 1, 8'h00, 4'b0110, 4'b1110, 1'b1, 1'b0);

        issue(4'hB, 8'h00, 8'h00, 1'b0);
        finish_op("dec", 1, 8'hFF, 4'b1000, 4'b1100, 1'b1, 1'b0);

        issue(4'hA, 8'h7F, 8'h00, 1'b0);
        finish_op("inc", 1, 8'h80, 4'b1000, 4'b1100, 1'b1, 1'b0);

        issue(4'h6, 8'h81, 8'h00, 1'b0);
        finish_op("asl", 1, 8'h02, 4'b0010, 4'b1110, 1'b1, 1'b0);

        issue(4'h8, 8'h80, 8'h00, 1'b1);
        finish_op("rol", 1, 8'h01, 4'b0010, 4'b1110, 1'b1, 1'b0);

        issue(4'h5, 8'hFF, 8'hFF, 1'b0);
        finish_op("eor", 1, 8'h00, 4'b0100, 4'b1100, 1'b1, 1'b0);

        // Back-pressure: result held, pending command not accepted
        issue(4'h3, 8'hF0, 8'h3C, 1'b0);
        @(posedge clk);
        #1;
        check("hold_first_valid", res_valid, 1'b1);
        cmd_op    = 4'h4;
        cmd_a     = 8'h0F;
        cmd_b     = 8'h30;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", res_valid, 1'b1);
            check("hold_data",  res_data, 8'h30);
            check("hold_ready", cmd_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("hold_release_valid", res_valid, 1'b0);
        check("hold_release_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("ora_accepted", cmd_ready, 1'b0);
        finish_op("ora", 1, 8'h3F, 4'b0000, 4'b1100, 1'b1, 1'b0);

        // Reset in the middle of EXEC
        issue(4'h0, 8'h12, 8'h34, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", res_valid, 1'b0);
        check("mid_rst_data",  res_data, 8'h00);
        check("mid_rst_flags", res_flags, 4'b0000);
        check("mid_rst_we",    res_flag_we, 4'b0000);
        check("mid_rst_ai",    alu_AI, 8'h00);
        check("mid_rst_ready", cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", cmd_ready, 1'b1);
        issue(4'hE, 8'h55, 8'hAA, 1'b1);
        finish_op("illegal", 1, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b1);

`ifdef ALU_SEQ_DECIMAL_EN
        cmd_d = 1'b1;
        issue(4'h0, 8'h09, 8'h01, 1'b0);
        finish_op("bcd_09_01", 2, 8'h10, 4'b0000, 4'b1111, 1'b1, 1'b0);
        issue(4'h0, 8'h99, 8'h01, 1'b0);
        finish_op("bcd_99_01", 2, 8'h00, 4'b0110, 4'b1111, 1'b1, 1'b0);
        issue(4'h1, 8'h10, 8'h01, 1'b1);
        finish_op("bcd_sbc_bin", 1, 8'h0F, 4'b0010, 4'b1111, 1'b1, 1'b0);
        cmd_d = 1'b0;
`else
        issue(4'h0, 8'h09, 8'h01, 1'b0);
        finish_op("bin_09_01", 1, 8'h0A, 4'b0000, 4'b1111, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
